packet_arbiter: RTL and testbench

//  N-to-1 merge of payload streams into one tagged packet stream; the inverse of the output router.

---
 rtl/packet_arbiter_pkg.sv | 38 +++
 rtl/packet_arbiter_if.sv | 27 ++
 rtl/packet_arbiter_rr.sv | 34 +++
 rtl/packet_arbiter.sv | 61 ++++++
 tb/tb_packet_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/packet_arbiter_pkg.sv
// Shared configuration, types and the round-robin search used by the packet arbiter.
package packet_arbiter_pkg;

  localparam int unsigned P_NBITS    = 32;
  localparam int unsigned P_NOUTPUTS = 8;
  localparam int unsigned TW         = $clog2(P_NOUTPUTS);
  localparam int unsigned PW         = P_NBITS - TW;

  typedef logic [P_NOUTPUTS-1:0] req_t;
  typedef logic [TW-1:0]         idx_t;
  typedef logic [PW-1:0]         payload_t;

  typedef struct packed {
    idx_t     tag;
    payload_t payload;
  } packet_t;

  typedef struct packed {
    logic hit;
    idx_t idx;
  } pick_t;

  // First set request at or after ptr, wrapping; descending loop lets the closest hit win.
  function automatic pick_t rr_pick(input req_t req, input idx_t ptr);
    pick_t pick;
    idx_t  idx;
    pick = '0;
    for (int k = int'(P_NOUTPUTS) - 1; k >= 0; k--) begin
      idx = ptr + idx_t'(k);
      if (req[idx]) begin
        pick.hit = 1'b1;
        pick.idx = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/packet_arbiter_if.sv
// Input streams and tagged output stream of the packet arbiter.
interface packet_arbiter_if
  import packet_arbiter_pkg::*;
#(
  parameter int unsigned p_nbits    = P_NBITS,
  parameter int unsigned p_noutputs = P_NOUTPUTS
);
  localparam int unsigned LTW = $clog2(p_noutputs);
  localparam int unsigned LPW = p_nbits - LTW;

  logic [p_noutputs-1:0] valid;
  logic [p_noutputs-1:0] ready_out;
  logic [LPW-1:0]        message_in [p_noutputs];
  logic                  valid_out;
  logic                  ready;
  logic [p_nbits-1:0]    message_out;

  modport master (
    output valid, message_in, ready,
    input  ready_out, valid_out, message_out
  );

  modport slave (
    input  valid, message_in, ready,
    output ready_out, valid_out, message_out
  );
endinterface

// File: rtl/packet_arbiter_rr.sv
// Round-robin arbiter: one-hot grant from a request vector, pointer advances past each grant.
module rr_arbiter_vrtl
  import packet_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  req_t req,
  input  logic en,
  output req_t gnt_c,
  output idx_t gnt_idx_c,
  output logic gnt_vld_c
);

  idx_t  ptr_q, ptr_d;
  pick_t pick_c;

  always_comb begin
    pick_c    = rr_pick(req, ptr_q);
    gnt_vld_c = en & pick_c.hit;
    gnt_idx_c = pick_c.idx;
    gnt_c     = '0;
    ptr_d     = ptr_q;
    if (gnt_vld_c) begin
      gnt_c = req_t'(1) << pick_c.idx;
      ptr_d = pick_c.idx + idx_t'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/packet_arbiter.sv
// N-to-1 merge of payload streams into one tagged, registered packet stream.
module packet_arbiter
  import packet_arbiter_pkg::*;
#(
  parameter int unsigned p_nbits    = P_NBITS,
  parameter int unsigned p_noutputs = P_NOUTPUTS
) (
  input logic             clk,
  input logic             reset,
  packet_arbiter_if.slave bus
);

  logic               free_c;
  logic               gnt_vld_c;
  req_t               gnt_c;
  idx_t               gnt_idx_c;
  payload_t           payload_c;
  packet_t            pkt_c;
  logic               valid_out_q, valid_out_d;
  logic [p_nbits-1:0] message_out_q, message_out_d;

  // Output register can take a new packet when empty or draining this cycle.
  assign free_c = ~valid_out_q | bus.ready;

  rr_arbiter_vrtl u_rr (
    .clk       (clk),
    .reset     (reset),
    .req       (bus.valid),
    .en        (free_c & reset),
    .gnt_c     (gnt_c),
    .gnt_idx_c (gnt_idx_c),
    .gnt_vld_c (gnt_vld_c)
  );

  assign payload_c = bus.message_in[gnt_idx_c];
  assign pkt_c     = '{tag: gnt_idx_c, payload: payload_c};

  always_comb begin
    valid_out_d   = valid_out_q;
    message_out_d = message_out_q;
    if (free_c) begin
      valid_out_d = gnt_vld_c;
      if (gnt_vld_c) message_out_d = p_nbits'(pkt_c);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out_q   <= 1'b0;
      message_out_q <= '0;
    end else begin
      valid_out_q   <= valid_out_d;
      message_out_q <= message_out_d;
    end
  end

  assign bus.ready_out   = gnt_c;
  assign bus.valid_out   = valid_out_q;
  assign bus.message_out = message_out_q;

endmodule

// File: tb/tb_packet_arbiter.sv
// Scoreboard bench for packet_arbiter: reference round-robin model plus directed scenarios.
module tb_packet_arbiter;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  packet_arbiter_if #(.p_nbits(32), .p_noutputs(8)) bus ();
  packet_arbiter #(.p_nbits(32), .p_noutputs(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  src_v;
  logic [28:0] src_m [N];
  logic [7:0]  refill;
  logic        rdy;
  int          m_ptr;
  logic        m_vout;
  logic [31:0] sb [$];
  logic        acc_hit;
  int          acc_idx;
  logic [31:0] held;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    bus.valid = src_v;
    bus.ready = rdy;
    for (int i = 0; i < N; i++) bus.message_in[i] = src_m[i];
  endtask

  // Compare DUT against the reference model, then advance the model across the next edge.
  task automatic monitor();
    logic       free;
    logic [7:0] exp_ro;
    int         i;
    acc_hit = 1'b0;
    acc_idx = 0;
    if (!reset) begin
      check("rst_ready_out", bus.ready_out, 0);
      check("rst_valid_out", bus.valid_out, 0);
      check("rst_message_out", bus.message_out, 0);
      m_vout = 1'b0;
      m_ptr  = 0;
      sb.delete();
    end else begin
      check("valid_out", bus.valid_out, m_vout);
      if (m_vout && rdy) begin
        if (sb.size() == 0) check("sb_empty", sb.size(), 1);
        else                check("dequeue_pkt", bus.message_out, sb.pop_front());
      end
      free   = !m_vout || rdy;
      exp_ro = '0;
      if (free) begin
        for (int k = 0; k < N; k++) begin
          i = (m_ptr + k) % N;
          if (src_v[i] && !acc_hit) begin
            acc_hit = 1'b1;
            acc_idx = i;
          end
        end
      end
      if (acc_hit) exp_ro[acc_idx] = 1'b1;
      check("ready_out", bus.ready_out, exp_ro);
      if (acc_hit) begin
        sb.push_back({3'(acc_idx), src_m[acc_idx]});
        m_ptr  = (acc_idx + 1) % N;
        m_vout = 1'b1;
      end else if (free) begin
        m_vout = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (acc_hit) begin
      if (refill[acc_idx]) src_m[acc_idx] = 29'($urandom);
      else                 src_v[acc_idx] = 1'b0;
    end
    drive();
  endtask

  initial begin
    m_ptr  = 0;
    m_vout = 1'b0;
    rdy    = 1'b1;
    refill = '0;
    src_v  = 8'hFF;
    for (int i = 0; i < N; i++) src_m[i] = 29'($urandom);
    drive();
    reset = 1'b1;
    #2 reset = 1'b0;

    // Reset held with every input requesting.
    repeat (3) step();
    reset = 1'b1;
    src_v = '0;
    drive();
    step();

    // Single source, tag 5 prepended.
    src_v    = 8'h20;
    src_m[5] = 29'h0ABCDEF;
    drive();
    step();
    check("t2_message_out", bus.message_out, 32'hA0ABCDEF);
    check("t2_valid_out", bus.valid_out, 1);

    // Pointer at 6, only input 1 requesting: wrap to 1, pointer moves to 2.
    src_v = 8'h02;
    drive();
    step();
    check("t5_wrap_tag", bus.message_out[31:29], 1);
    src_v = 8'h05;
    drive();
    step();
    check("t5_ptr2_tag", bus.message_out[31:29], 2);
    step();
    check("t5_remaining_tag", bus.message_out[31:29], 0);

    // Async reset while a packet is held.
    src_v  = 8'hFF;
    refill = 8'hFF;
    for (int i = 0; i < N; i++) src_m[i] = 29'($urandom);
    drive();
    #2 reset = 1'b0;
    #1;
    check("t6_async_valid_out", bus.valid_out, 0);
    check("t6_async_message_out", bus.message_out, 0);
    repeat (2) step();
    reset = 1'b1;

    // Round robin from input 0 after reset, one packet per cycle.
    for (int k = 0; k < 9; k++) begin
      step();
      check("t3_rr_tag", bus.message_out[31:29], k % N);
      check("t3_rr_valid", bus.valid_out, 1);
    end

    // Backpressure for four cycles, then reload without a bubble.
    rdy = 1'b0;
    drive();
    step();
    held = bus.message_out;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t4_hold_msg", bus.message_out, held);
      check("t4_hold_valid", bus.valid_out, 1);
    end
    rdy = 1'b1;
    drive();
    step();
    check("t4_reload_tag", bus.message_out[31:29], 1);
    check("t4_reload_valid", bus.valid_out, 1);

    // Random traffic: sources hold until accepted, random downstream stall.
    for (int c = 0; c < 60; c++) begin
      src_v  = src_v | 8'($urandom);
      refill = 8'($urandom);
      rdy    = 1'($urandom);
      drive();
      step();
    end

    // Drain: every accepted packet must have left.
    src_v  = '0;
    refill = '0;
    rdy    = 1'b1;
    drive();
    repeat (3) step();
    check("drain_sb_size", sb.size(), 0);
    check("drain_valid_out", bus.valid_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
